// File: rtl/async_mem_if.sv
// async_mem_if: shared-address RAM bus carrying write and read channels
interface async_mem_if #(
    parameter int asz = 8,
    parameter int dsz = 8
);
    logic [asz-1:0] addr;
    logic [dsz-1:0] wr_data;
    logic           wr_cs;
    logic           rd_cs;
    logic [dsz-1:0] rd_data;
    modport master (output addr, wr_data, wr_cs, rd_cs, input rd_data);
    modport slave (input addr, wr_data, wr_cs, rd_cs, output rd_data);
endinterface

// File: rtl/async_mem.sv
// async_mem: sync-write/async-read register-file RAM; ASYNC_MEM_BYPASS_EN adds write-first read bypass
module async_mem #(
    parameter int asz = 8,
    parameter int dsz = 8,
    parameter int depth = 127
) (
    input logic wr_clk,
    input logic reset,
    async_mem_if.slave bus
);
    localparam int aw = depth > 1 ? $clog2(depth) : 1;
    logic [dsz-1:0] mem [depth];
    logic [aw-1:0]  idx;
    logic           in_range;
    logic           bypass;
    assign idx = bus.addr[aw-1:0];
    assign in_range = 32'(bus.addr) < 32'(depth);
`ifdef ASYNC_MEM_BYPASS_EN
    assign bypass = bus.wr_cs && !reset;
`else
    assign bypass = 1'b0;
`endif
    // reset clears every word and overrides a coincident write; out-of-range writes are dropped
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        end else if (bus.wr_cs && in_range) begin
            mem[idx] <= bus.wr_data;
        end
    end
    // open-bus ones when deselected or out of range, otherwise stored word (or in-flight data when bypassing)
    always_comb begin
        bus.rd_data = !(bus.rd_cs && in_range) ? '1 : bypass ? bus.wr_data : mem[idx];
    end
endmodule

// File: tb/tb_async_mem.sv
// tb_async_mem: scoreboard-driven self-checking bench for async_mem
module tb_async_mem;
    logic wr_clk = 1'b0;
    logic reset;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] model [0:126];
    logic [7:0] exp_q [$];

    async_mem_if #(.asz(8), .dsz(8)) bus ();
    async_mem #(.asz(8), .dsz(8), .depth(127)) dut (.wr_clk(wr_clk), .reset(reset), .bus(bus));

    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_push(input int a);
        if (a < 127 && bus.rd_cs) exp_q.push_back(model[a]);
        else exp_q.push_back(8'hFF);
    endtask

    task automatic rd(input string tag, input int a);
        bus.addr = 8'(a);
        bus.rd_cs = 1'b1;
        expect_push(a);
        #1;
        check(tag, bus.rd_data, exp_q.pop_front());
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        @(negedge wr_clk);
        bus.addr = 8'(a);
        bus.wr_data = d;
        bus.wr_cs = 1'b1;
        @(posedge wr_clk);
        #1;
        bus.wr_cs = 1'b0;
        if (a < 127) model[a] = d;
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        reset = 1'b1;
        @(posedge wr_clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 127; i++) model[i] = 8'h00;
    endtask

    initial begin
        reset = 1'b1;
        bus.addr = '0;
        bus.wr_data = '0;
        bus.wr_cs = 1'b0;
        bus.rd_cs = 1'b0;
        for (int i = 0; i < 127; i++) model[i] = 8'h00;
        repeat (2) @(posedge wr_clk);
        #1;
        reset = 1'b0;
        rd("por_a0", 0);
        rd("por_a126", 126);

        wr(0, 8'hA5);
        wr(126, 8'h3C);
        rd("pre_rst_a0", 0);
        rd("pre_rst_a126", 126);
        do_reset();
        rd("rst_a0", 0);
        rd("rst_a126", 126);

        for (int a = 0; a < 127; a++) begin
            wr(a, 8'(a) ^ 8'h5A);
            rd("sweep_imm", a);
        end
        for (int a = 0; a < 127; a++) rd("sweep_all", a);

        wr(127, 8'h77);
        rd("oor_127", 127);
        wr(255, 8'h77);
        rd("oor_255", 255);
        rd("oor_alias_a0", 0);
        rd("oor_alias_a126", 126);

        bus.addr = 8'd0;
        bus.rd_cs = 1'b0;
        expect_push(0);
        #1;
        check("rdcs_off", bus.rd_data, exp_q.pop_front());

        @(negedge wr_clk);
        bus.addr = 8'd3;
        bus.wr_cs = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.wr_data = k[0] ? 8'h00 : 8'h11;
            @(negedge wr_clk);
        end
        rd("wrcs_off", 3);

        wr(5, 8'h20);
        @(negedge wr_clk);
        bus.addr = 8'd5;
        bus.wr_data = 8'h21;
        bus.wr_cs = 1'b1;
        bus.rd_cs = 1'b1;
`ifdef ASYNC_MEM_BYPASS_EN
        exp_q.push_back(8'h21);
`else
        exp_q.push_back(8'h20);
`endif
        #1;
        check("rdw_before", bus.rd_data, exp_q.pop_front());
        @(posedge wr_clk);
        #1;
        bus.wr_cs = 1'b0;
        model[5] = 8'h21;
        rd("rdw_after", 5);

        wr(10, 8'h44);
        rd("pri_pre", 10);
        @(negedge wr_clk);
        reset = 1'b1;
        bus.addr = 8'd10;
        bus.wr_data = 8'hEE;
        bus.wr_cs = 1'b1;
        bus.rd_cs = 1'b1;
        exp_q.push_back(8'h44);
        #1;
        check("pri_during_rst", bus.rd_data, exp_q.pop_front());
        @(posedge wr_clk);
        #1;
        reset = 1'b0;
        bus.wr_cs = 1'b0;
        for (int i = 0; i < 127; i++) model[i] = 8'h00;
        rd("pri_a10", 10);
        rd("pri_a5", 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/async_mem.md
Name: async_mem

Overview:
- Small register-file RAM with a synchronous write port and a combinational (asynchronous) read port, sharing one address bus.
- Used as Game Boy High RAM (FF80h–FFFEh, 127 bytes) behind the MMU.
- The MMU presents the address already rebased to zero and qualifies writes with its own chip-select and write strobe.

Parameters:
- asz, 8, address width in bits.
- dsz, 8, data word width in bits.
- depth, 127, number of implemented words (valid addresses 0..depth-1); must satisfy 1 <= depth <= 2**asz.

Ports:
- wr_clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears the array.
- addr  input  asz  shared read/write word address; narrower sources are zero-extended by the caller.
- wr_data  input  dsz  write data.
- wr_cs  input  1  write enable; active high, sampled at the rising edge of wr_clk.
- rd_cs  input  1  read enable; combinational.
- rd_data  output  dsz  read data; combinational.

Behaviour:
- Interface: one clock (wr_clk); reset is synchronous and active-high.
- Storage: array of depth words, each dsz bits. No other state.
- Reset:
  - On a wr_clk edge with reset=1, every word is set to 0.
  - A write presented in the same cycle is discarded; reset has priority.
  - After reset, reads of any valid address return 0.
- Write:
  - On a wr_clk edge with reset=0, wr_cs=1 and addr<depth: mem[addr] <= wr_data.
  - Takes effect at that edge; 1-cycle write latency.
- Out-of-range write: addr>=depth with wr_cs=1 is ignored; no aliasing or wrap onto valid words.
- Read (combinational, zero-latency):
  - rd_cs=1 and addr<depth: rd_data = mem[addr].
  - rd_cs=1 and addr>=depth: rd_data = all ones (8'hFF at dsz=8), matching an open bus.
  - rd_cs=0: rd_data = all ones.
- Read-during-write, same address, feature off: rd_data shows the old contents until the edge, then the new value.
- Ordering: a write at edge N is visible to a combinational read immediately after edge N.
- Concurrent cs: wr_cs and rd_cs are independent; both high is legal.
- rd_data never depends on reset directly, only on array contents.
- Reset mid-operation:
  - A write coincident with reset is lost.
  - Reads stay combinational, so during reset they show pre-reset contents until the reset edge clears them.
- X-safety: an X on wr_cs at an edge without reset must not corrupt any word other than mem[addr].

Optional Feature:
- Macro: ASYNC_MEM_BYPASS_EN.
- Defined: write-first bypass. When rd_cs=1, wr_cs=1, reset=0 and addr<depth, rd_data = wr_data combinationally in the same cycle, before the edge.
- Not defined: rd_data shows the stored (old) word until the write edge.
- Array contents and write timing are identical either way.

Test Plan:
- Reset clear: write 8'hA5 to addr 0 and 8'h3C to addr 126; assert reset for 1 cycle; rd_cs=1 at addr 0, 126 -> rd_data=8'h00 at both.
- Write/read sweep: write each addr a (0..126) with a^8'h5A; read all with rd_cs=1 -> rd_data=a^8'h5A for each, valid immediately after the write edge.
- Out-of-range: write 8'h77 at addr 127 and 255 -> rd_data=8'hFF at both; addr 0 and 126 retain prior values (no aliasing).
- Chip-selects:
  - rd_cs=0 at a written addr -> rd_data=8'hFF.
  - wr_cs=0 with wr_data=8'h11 toggling over 3 edges -> stored word unchanged.
- Read-during-write: addr 5 holds 8'h20; present wr_cs=1, wr_data=8'h21, rd_cs=1 before the edge -> rd_data=8'h20 without the macro (8'h21 with ASYNC_MEM_BYPASS_EN); after the edge, 8'h21 in both builds.
- Reset priority: reset=1 and wr_cs=1 with 8'hEE at addr 10 on the same edge -> after the edge, addr 10 reads 8'h00.
